// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory slave: byte/halfword/word accesses to an internal word array,
// optional wait states and two-cycle ERROR responses for illegal transfers.
module ahb_dmem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [2:0] {StIdle, StWait, StLast, StErr1, StErr2} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W+1:0] off_q;
    logic [1:0]       size_q;
    logic             write_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic        in_range, addr_err, can_accept, accept;

    assign offset   = HADDR - BASE_ADDR;
    assign in_range = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, HADDR} < ADDR_END);
    assign addr_err = !in_range || HSIZE[2] || (HSIZE == 3'b011) ||
                      ((HSIZE == 3'b001) && HADDR[0]) ||
                      ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

    // A new address phase may only overlap the final (ready) cycle of a data phase.
    assign can_accept = (state_q == StIdle) || (state_q == StLast) || (state_q == StErr2);
    assign accept     = can_accept && HSEL && HTRANS[1] && HREADY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) state_d = StLast;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            if (addr_err) begin
                state_d = StErr1;
            end else if (WAIT_STATES > 0) begin
                state_d = StWait;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = StLast;
            end
        end
    end

    always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            off_q   <= '0;
            size_q  <= 2'b00;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                off_q   <= offset[IDX_W+1:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
        end
    end

    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic             commit;

    assign idx    = off_q[IDX_W+1:2];
    assign commit = (state_q == StLast) && write_q;

    // Store data arrives right-justified; replicate it so each enabled lane sees its byte.
    always_comb begin
        be     = 4'b0000;
        wlanes = HWDATA;
        unique case (size_q)
            2'b00: begin
                be     = 4'b0001 << off_q[1:0];
                wlanes = {4{HWDATA[7:0]}};
            end
            2'b01: begin
                be     = off_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{HWDATA[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    logic [31:0] shifted;
    assign shifted = mem[idx] >> {off_q[1:0], 3'b000};

    always_comb begin
        HRDATA = 32'h0;
        if ((state_q == StLast) && !write_q) begin
            unique case (size_q)
                2'b00:   HRDATA = {24'h0, shifted[7:0]};
                2'b01:   HRDATA = {16'h0, shifted[15:0]};
                default: HRDATA = shifted;
            endcase
        end
    end

    assign HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
    assign HRESP     = (state_q == StErr1) || (state_q == StErr2);

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset[31:IDX_W+2]};

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Directed bench for ahb_dmem_slave: one zero-wait instance at base 0, one 3-wait-state
// instance at a non-zero base.
module tb_ahb_dmem_slave;

    localparam logic [31:0] B3 = 32'h0001_0000;

    logic        CLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        hsel0 = 1'b0, hsel3 = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = 32'h0;
    logic        hready_low = 1'b0;

    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;
    logic        hready0, hready3;

    assign hready0 = hready_low ? 1'b0 : hreadyout0;
    assign hready3 = hreadyout3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ahb_dmem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(HWDATA), .HREADY(hready0), .HRDATA(hrdata0), .HREADYOUT(hreadyout0),
        .HRESP(hresp0)
    );

    ahb_dmem_slave #(.DEPTH_WORDS(256), .BASE_ADDR(B3), .WAIT_STATES(3)) dut3 (
        .CLK(CLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(HWDATA), .HREADY(hready3), .HRDATA(hrdata3), .HREADYOUT(hreadyout3),
        .HRESP(hresp3)
    );

    // Single transfer; entered and left 1 time unit after a rising edge.
    task automatic xfer(input bit use3, input logic [31:0] addr, input logic [2:0] size,
                        input logic wr, input logic [31:0] wd, output logic [31:0] rd,
                        output logic resp, output int lows, output logic lo_resp);
        hsel0  = !use3;
        hsel3  = use3;
        HADDR  = addr;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = size;
        @(posedge CLK); #1;
        hsel0   = 1'b0;
        hsel3   = 1'b0;
        HTRANS  = 2'b00;
        HWDATA  = wd;
        lows    = 0;
        lo_resp = 1'b0;
        while (((use3 ? hreadyout3 : hreadyout0) == 1'b0) && (lows < 40)) begin
            if (lows == 0) lo_resp = use3 ? hresp3 : hresp0;
            lows++;
            @(posedge CLK); #1;
        end
        rd   = use3 ? hrdata3 : hrdata0;
        resp = use3 ? hresp3 : hresp0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b want 1", hreadyout0); end
        checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b want 0", hresp0); end
        checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", hrdata0); end
        @(posedge CLK); #1;
        HRESETn = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_word_byte();
        logic [31:0] rd; logic resp, lr; int lows;
        xfer(0, 32'h10, 3'b010, 1, 32'hDEADBEEF, rd, resp, lows, lr);
        checks++; if (lows !== 0 || resp !== 1'b0) begin errors++; $display("FAIL word_store lows=%0d resp=%b want 0/0", lows, resp); end
        xfer(0, 32'h12, 3'b000, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h0000_00AD) begin errors++; $display("FAIL byte_load got %h want 000000ad", rd); end
        checks++; if (lows !== 0 || resp !== 1'b0) begin errors++; $display("FAIL byte_load_resp lows=%0d resp=%b want 0/0", lows, resp); end
        checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL idle_hrdata got %h want 0", hrdata0); end
    endtask

    task automatic test_halfword_byte_store();
        logic [31:0] rd; logic resp, lr; int lows;
        xfer(0, 32'h12, 3'b001, 1, 32'h0000_1234, rd, resp, lows, lr);
        xfer(0, 32'h10, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL half_store got %h want 1234beef", rd); end
        xfer(0, 32'h10, 3'b001, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL half_load got %h want 0000beef", rd); end
        xfer(0, 32'h11, 3'b000, 1, 32'hFFFF_FFA5, rd, resp, lows, lr);
        xfer(0, 32'h10, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h1234_A5EF) begin errors++; $display("FAIL byte_store got %h want 1234a5ef", rd); end
        xfer(0, 32'h13, 3'b000, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h0000_0012) begin errors++; $display("FAIL byte_load_hi got %h want 00000012", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic resp, lr; int lows;
        xfer(1, B3 + 32'h4, 3'b010, 1, 32'hCAFE_F00D, rd, resp, lows, lr);
        checks++; if (lows !== 3 || resp !== 1'b0) begin errors++; $display("FAIL ws_store lows=%0d resp=%b want 3/0", lows, resp); end
        xfer(1, B3 + 32'h4, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (lows !== 3 || resp !== 1'b0) begin errors++; $display("FAIL ws_load lows=%0d resp=%b want 3/0", lows, resp); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_load_data got %h want cafef00d", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic resp, lr; int lows;
        xfer(0, 32'h2, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (lows !== 1 || lr !== 1'b1 || resp !== 1'b1) begin errors++; $display("FAIL misaligned lows=%0d r1=%b r2=%b want 1/1/1", lows, lr, resp); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_data got %h want 0", rd); end
        xfer(0, 32'h0, 3'b010, 1, 32'h600D_F00D, rd, resp, lows, lr);
        xfer(0, 32'h1000, 3'b010, 1, 32'hBAD0_BAD0, rd, resp, lows, lr);
        checks++; if (lows !== 1 || lr !== 1'b1 || resp !== 1'b1) begin errors++; $display("FAIL out_of_range lows=%0d r1=%b r2=%b want 1/1/1", lows, lr, resp); end
        xfer(0, 32'h0, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h600D_F00D) begin errors++; $display("FAIL oor_no_write got %h want 600df00d", rd); end
        xfer(0, 32'h11, 3'b001, 1, 32'h0000_FFFF, rd, resp, lows, lr);
        checks++; if (resp !== 1'b1) begin errors++; $display("FAIL misaligned_half resp=%b want 1", resp); end
        xfer(0, 32'h10, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h1234_A5EF) begin errors++; $display("FAIL err_store_no_write got %h want 1234a5ef", rd); end
        xfer(0, 32'h10, 3'b011, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (lows !== 1 || resp !== 1'b1) begin errors++; $display("FAIL bad_size lows=%0d resp=%b want 1/1", lows, resp); end
        xfer(1, B3 - 32'h4, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (lows !== 1 || lr !== 1'b1 || resp !== 1'b1) begin errors++; $display("FAIL below_base_ws lows=%0d r1=%b r2=%b want 1/1/1", lows, lr, resp); end
    endtask

    task automatic test_hready_low();
        logic [31:0] rd; logic resp, lr; int lows;
        xfer(0, 32'h30, 3'b010, 1, 32'h0102_0304, rd, resp, lows, lr);
        hready_low = 1'b1;
        hsel0  = 1'b1;
        HADDR  = 32'h30;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HSIZE  = 3'b010;
        @(posedge CLK); #1;
        hsel0      = 1'b0;
        HTRANS     = 2'b00;
        HWDATA     = 32'hFFFF_FFFF;
        hready_low = 1'b0;
        checks++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin errors++; $display("FAIL hready_low_out rdy=%b resp=%b want 1/0", hreadyout0, hresp0); end
        @(posedge CLK); #1;
        xfer(0, 32'h30, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL hready_low_no_capture got %h want 01020304", rd); end
    endtask

    task automatic test_back_to_back();
        hsel0  = 1'b1;
        HADDR  = 32'h40;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HSIZE  = 3'b010;
        @(posedge CLK); #1;
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL b2b_store_ready got %b want 1", hreadyout0); end
        HWDATA = 32'h0BAD_C0DE;
        HWRITE = 1'b0;
        @(posedge CLK); #1;
        hsel0  = 1'b0;
        HTRANS = 2'b00;
        checks++; if (hreadyout0 !== 1'b1 || hrdata0 !== 32'h0BAD_C0DE) begin errors++; $display("FAIL b2b_load rdy=%b got %h want 1/0badc0de", hreadyout0, hrdata0); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic resp, lr; int lows;
        xfer(1, B3 + 32'h20, 3'b010, 1, 32'h1111_1111, rd, resp, lows, lr);
        hsel3  = 1'b1;
        HADDR  = B3 + 32'h20;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HSIZE  = 3'b010;
        @(posedge CLK); #1;
        hsel3  = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'h55AA_55AA;
        checks++; if (hreadyout3 !== 1'b0) begin errors++; $display("FAIL mid_wait_ready got %b want 0", hreadyout3); end
        HRESETn = 1'b0;
        #1;
        checks++; if (hreadyout3 !== 1'b1 || hresp3 !== 1'b0 || hrdata3 !== 32'h0) begin errors++; $display("FAIL async_reset rdy=%b resp=%b data=%h want 1/0/0", hreadyout3, hresp3, hrdata3); end
        repeat (3) @(posedge CLK);
        #1;
        HRESETn = 1'b1;
        @(posedge CLK); #1;
        xfer(1, B3 + 32'h20, 3'b010, 0, 32'h0, rd, resp, lows, lr);
        checks++; if (rd !== 32'h1111_1111 || lows !== 3) begin errors++; $display("FAIL reset_drops_write got %h lows=%0d want 11111111/3", rd, lows); end
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_halfword_byte_store();
        test_wait_states();
        test_errors();
        test_hready_low();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_dmem_slave.md
# ahb_dmem_slave

AHB-Lite data-memory responder attached to the core's data-side AHB master (HADDR_D/HWDATA_D/HTRANS_D…). Decodes single transfers, services byte/halfword/word loads and stores against an internal word array with configurable wait states, and returns two-cycle ERROR responses for illegal accesses. Data is right-justified on both HWDATA and HRDATA, matching the core's memory stage, which extracts load bytes from bit 0 and drives store data unshifted.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per OKAY transfer, 0..15.
- CLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address (address phase).
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal.
- HBURST  in  3  ignored (every transfer treated as single).
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  32  write data (data phase), right-justified.
- HREADY  in  1  bus-level ready; gates address-phase capture.
- HRDATA  out  32  read data, right-justified and zero-extended to 32 bits.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation
- Address phase accepted when HSEL && HTRANS[1] && HREADY; registers addr, size, write and an error flag. IDLE/BUSY or !HSEL with HREADY high creates no data phase; slave answers OKAY, zero wait.
- Error flag set when any of: HADDR outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS); HSIZE>010; halfword with HADDR[0]=1; word with HADDR[1:0]≠00.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: on accept with error → ERR1; on accept with WAIT_STATES>0 → WAIT (counter loaded with WAIT_STATES-1); otherwise → LAST.
  - WAIT: HREADYOUT=0; counter decrements; at 0 → LAST.
  - LAST: HREADYOUT=1, HRESP=0; write committed / read data driven. A new transfer accepted in this cycle follows the IDLE rules; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts the next address phase like IDLE (core may pipeline or cancel it).
- Write: at the rising edge ending LAST. Word index = (addr-BASE_ADDR)>>2. Byte: HWDATA[7:0] → lane addr[1:0]. Halfword: HWDATA[15:0] → lanes {addr[1],0}+1:{addr[1],0}. Word: all lanes. Unselected lanes unchanged. Errored transfers never write.
- Read: during LAST, HRDATA = selected byte/halfword/word shifted down to bit 0, upper bits zero (core sign-extends). HRDATA = 0 in every other cycle.

## Timing
- Reset (HRESETn low, any cycle): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter 0, any pending write dropped. Memory contents are not reset or modified.
- Reset mid-WAIT or mid-ERR1: outputs return to reset values immediately (asynchronous); no write occurs.
- OKAY latency: data phase is WAIT_STATES+1 cycles; WAIT_STATES=0 gives single-cycle data phase.
- Pipelined back-to-back: address phase N+1 overlaps LAST of N; write N commits at the same edge that captures N+1, so a read of the same address in N+1 returns the new data.
- Error latency: exactly 2 data-phase cycles regardless of WAIT_STATES.
- HREADY low (another slave stretching): no capture; in IDLE outputs stay HREADYOUT=1, HRESP=0.

## Test plan
- Reset: hold HRESETn low 3 cycles mid-WAIT → HREADYOUT=1, HRESP=0, HRDATA=0; pending store leaves memory unchanged.
- Word store 32'hDEADBEEF to BASE+0x10, then byte load (HSIZE=000) at BASE+0x12 → HRDATA=32'h000000AD, OKAY, zero wait.
- Halfword store 32'h0000_1234 to BASE+0x12 over 32'hDEADBEEF → word load BASE+0x10 returns 32'h1234BEEF.
- WAIT_STATES=3, word load → HREADYOUT low exactly 3 cycles, then high with data, HRESP=0.
- Misaligned word load at BASE+0x2 and out-of-range address BASE+4*DEPTH_WORDS → HREADYOUT 0 then 1 with HRESP=1 both cycles; no memory change on errored store.
- Back-to-back NONSEQ store then load to same address, WAIT_STATES=0 → load returns stored value in the cycle immediately after the store's data phase.
